pebble_loader: RTL and testbench

//  Host-side harness for the Pebble core: the writer/reader opposite the core's instruction fetch and data-memory path.

---
 rtl/pebble_pkg.sv | 23 ++
 rtl/pebble_out_reg.sv | 32 +++
 rtl/pebble_loader.sv | 136 +++++++++++++
 tb/tb_pebble_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pebble_pkg.sv
// Shared types and widths for the Pebble host-side loader.
package pebble_pkg;

  localparam int IM_AW   = 10;
  localparam int DM_AW   = 8;
  localparam int INSTR_W = 9;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    DUMP = 3'd4
  } loader_state_t;

  // One dump-stream beat: data byte plus end-of-window marker.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } dump_beat_t;

endpackage

// File: rtl/pebble_out_reg.sv
// Single-entry valid/ready holding register for the dump byte stream.
// Accepts a new beat on the same edge the held one is taken, so a
// steadily ready host sees no bubbles.
module pebble_out_reg
  import pebble_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  dump_beat_t in_beat,
  output logic       out_valid,
  input  logic       out_ready,
  output dump_beat_t out_beat
);

  assign in_ready = !out_valid || out_ready;

  // Hold the beat until the host takes it; refill or drain on handshake.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_beat  <= in_beat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pebble_loader.sv
// Host harness for the Pebble core: loads instruction memory while the
// core is held in reset, runs it until Done or timeout, then streams a
// data-memory window back to the host.
module pebble_loader
  import pebble_pkg::*;
#(
  parameter int IM_DEPTH  = 1024,
  parameter int DUMP_BASE = 0,
  parameter int DUMP_LEN  = 32,
  parameter int TIMEOUT   = 65535,
  parameter int HOLD      = 2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_data,
  input  logic               in_last,
  output logic               im_wen,
  output logic [IM_AW-1:0]   im_waddr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               core_reset,
  input  logic               core_done,
  output logic [DM_AW-1:0]   dm_raddr,
  input  logic [DATA_W-1:0]  dm_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy,
  output logic               overflow,
  output logic               timed_out
);

  localparam int LDW = IM_AW + 1;
  localparam logic [LDW-1:0]   IM_LIM    = LDW'(IM_DEPTH);
  localparam logic [15:0]      HOLD_LAST = 16'(HOLD - 1);
  localparam logic [15:0]      TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [8:0]       DLEN      = 9'(DUMP_LEN);
  localparam logic [8:0]       DLAST     = 9'(DUMP_LEN - 1);
  localparam logic [DM_AW-1:0] DBASE     = DM_AW'(DUMP_BASE);

  loader_state_t state, nxt;
  logic [LDW-1:0] ld_idx;   // next word index; saturates at IM_DEPTH
  logic [15:0]    cnt;      // hold cycles, then run cycles
  logic [8:0]     d_cnt;    // dump bytes fetched so far
  logic           xfer, done_ok, to_hit, push, beat_rdy;
  dump_beat_t     beat_in, beat_out;

  assign xfer       = in_valid && in_ready;
  assign core_reset = (state != RUN);
  assign busy       = (state != IDLE);
  // Done is ignored on the first run cycle while decode settles.
  assign done_ok    = (state == RUN) && (cnt != '0) && core_done;
  assign to_hit     = (state == RUN) && (cnt == TO_LAST) && !done_ok;
  assign push       = (state == DUMP) && (d_cnt != DLEN) && beat_rdy;
  assign beat_in    = '{data: dm_rdata, last: (d_cnt == DLAST)};

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      IDLE, LOAD:      if (xfer) nxt = in_last ? pebble_pkg::HOLD : LOAD;
      pebble_pkg::HOLD: if (cnt == HOLD_LAST) nxt = RUN;
      RUN:             if (done_ok || to_hit) nxt = DUMP;
      DUMP:            if (out_valid && out_ready && out_last) nxt = IDLE;
      default:         nxt = IDLE;
    endcase
  end

  // State register, load path, counters and dump address.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      im_wen    <= 1'b0;
      im_waddr  <= '0;
      im_wdata  <= '0;
      ld_idx    <= '0;
      overflow  <= 1'b0;
      timed_out <= 1'b0;
      cnt       <= '0;
      d_cnt     <= '0;
      dm_raddr  <= DBASE;
    end else begin
      state    <= nxt;
      in_ready <= (nxt == IDLE) || (nxt == LOAD);
      im_wen   <= 1'b0;
      if (xfer) begin
        if (state == IDLE) begin
          overflow  <= 1'b0;
          timed_out <= 1'b0;
          im_wen    <= 1'b1;
          im_waddr  <= '0;
          im_wdata  <= in_data;
          ld_idx    <= LDW'(1);
        end else if (ld_idx < IM_LIM) begin
          im_wen   <= 1'b1;
          im_waddr <= ld_idx[IM_AW-1:0];
          im_wdata <= in_data;
          ld_idx   <= ld_idx + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (state != nxt)
        cnt <= '0;
      else if (state == pebble_pkg::HOLD || state == RUN)
        cnt <= cnt + 1'b1;
      if (to_hit)
        timed_out <= 1'b1;
      if (state == RUN && nxt == DUMP) begin
        dm_raddr <= DBASE;
        d_cnt    <= '0;
      end else if (push) begin
        dm_raddr <= dm_raddr + 1'b1;
        d_cnt    <= d_cnt + 1'b1;
      end
    end
  end

  pebble_out_reg u_out (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .in_valid (push),
    .in_ready (beat_rdy),
    .in_beat  (beat_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_beat (beat_out)
  );

  assign out_data = beat_out.data;
  assign out_last = beat_out.last;

endmodule

// File: tb/tb_pebble_loader.sv
// Scoreboard bench for pebble_loader: expected writes/bytes are queued
// when stimulus is driven and popped as the DUT produces them.
module tb_pebble_loader;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       in_valid = 1'b0, in_last = 1'b0;
  logic [8:0] in_data = '0;
  logic       in_ready, im_wen, core_reset, out_valid, out_last, busy, overflow, timed_out;
  logic [9:0] im_waddr;
  logic [8:0] im_wdata;
  logic       core_done = 1'b0, out_ready = 1'b0;
  logic [7:0] dm_raddr, dm_rdata, out_data;
  logic [7:0] dmem [256];

  int n_vec = 0, n_err = 0, rx_cnt = 0;
  logic [18:0] im_q [$];   // {addr, data}
  logic [8:0]  dq   [$];   // {last, data}
  logic [8:0]  prog [$];
  logic        prev_stall = 1'b0;
  logic [9:0]  prev_word;

  always #5 Clk = ~Clk;
  assign dm_rdata = dmem[dm_raddr];

  pebble_loader #(.TIMEOUT(100)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .im_wen(im_wen), .im_waddr(im_waddr),
    .im_wdata(im_wdata), .core_reset(core_reset), .core_done(core_done),
    .dm_raddr(dm_raddr), .dm_rdata(dm_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .overflow(overflow), .timed_out(timed_out));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction-memory write monitor.
  always @(negedge Clk) begin
    if (Reset_n && im_wen) begin
      if (im_q.size() == 0) chk("im_spurious", {22'd0, im_waddr}, 32'h3FF_FFFF);
      else begin
        logic [18:0] e;
        e = im_q.pop_front();
        chk("im_waddr", {22'd0, im_waddr}, {22'd0, e[18:9]});
        chk("im_wdata", {23'd0, im_wdata}, {23'd0, e[8:0]});
      end
    end
  end

  // Dump stream monitor: ordering, last flag and hold-under-backpressure.
  always @(negedge Clk) begin
    if (!Reset_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) chk("out_stable", {22'd0, out_valid, out_last, out_data}, {22'd0, prev_word});
      if (out_valid && out_ready) begin
        rx_cnt++;
        if (dq.size() == 0) chk("dump_extra", {23'd0, out_last, out_data}, 32'hFFFF_FFFF);
        else begin
          logic [8:0] e;
          e = dq.pop_front();
          chk("dump_byte", {23'd0, out_last, out_data}, {23'd0, e});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_valid, out_last, out_data};
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom);
  endtask

  task automatic load();
    for (int i = 0; i < prog.size(); i++) begin
      int t = 0;
      in_valid = 1'b1;
      in_data  = prog[i];
      in_last  = (i == prog.size() - 1);
      if (i < 1024) im_q.push_back({10'(i), prog[i]});
      do begin @(negedge Clk); t++; end while (!in_ready && t < 200);
      if (t >= 200) chk("in_ready_timeout", 0, 1);
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic hold_check();
    int c = 0;
    while (core_reset && c < 20) begin @(posedge Clk); #1; c++; end
    chk("hold_cycles", c, 2);
  endtask

  task automatic run(input int done_cyc, input int exp_cyc);
    int n = 0;
    while (!core_reset && n < 1000) begin
      n++;
      if (done_cyc != 0 && n == done_cyc) core_done = 1'b1;
      @(posedge Clk); #1;
    end
    core_done = 1'b0;
    chk("run_cycles", n, exp_cyc);
  endtask

  task automatic dump(input int pct);
    int target = rx_cnt + 32, t = 0;
    for (int i = 0; i < 32; i++) dq.push_back({(i == 31), dmem[i]});
    while (rx_cnt < target && t < 2000) begin
      out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      @(posedge Clk); #1;
      t++;
    end
    out_ready = 1'b0;
    chk("dump_count", rx_cnt, target);
    chk("busy_after_dump", busy, 0);
  endtask

  initial begin
    #2;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outs", {im_wen, out_valid, out_last, busy, overflow, timed_out}, 0);
    chk("rst_im", {im_waddr, im_wdata}, 0);
    chk("rst_dm", {dm_raddr, out_data}, 0);
    @(posedge Clk); #1 Reset_n = 1'b1;
    repeat (2) @(posedge Clk); #1;

    // Fixed 3-word program, Done ten cycles into RUN, full-rate dump.
    fill_mem();
    prog = '{9'h1A5, 9'h003, 9'h0FF};
    load();
    chk("t1_in_ready_hold", in_ready, 0);
    hold_check();
    run(10, 10);
    chk("t1_timed_out", timed_out, 0);
    chk("t1_overflow", overflow, 0);
    dump(100);

    // Done already high on the first RUN cycle is ignored; random backpressure.
    fill_mem();
    prog = {};
    for (int i = 0; i < 5; i++) prog.push_back(9'($urandom));
    load();
    hold_check();
    run(1, 2);
    dump(50);

    // No Done: timeout after 100 RUN cycles, dump still complete.
    fill_mem();
    prog = '{9'h011, 9'h122};
    load();
    hold_check();
    run(0, 100);
    chk("t3_timed_out", timed_out, 1);
    dump(50);
    chk("t3_timed_out_sticky", timed_out, 1);

    // Single-word program straight from IDLE; reset while a dump byte waits.
    fill_mem();
    prog = '{9'h1FF};
    load();
    chk("t4_single_hold", in_ready, 0);
    chk("t4_timed_out_clr", timed_out, 0);
    hold_check();
    run(3, 3);
    repeat (5) @(posedge Clk); #1;
    chk("t4_first_valid", out_valid, 1);
    chk("t4_first_byte", out_data, dmem[0]);
    Reset_n = 1'b0;
    #1;
    chk("t4_rst_outs", {im_wen, out_valid, out_last, busy, overflow, timed_out, in_ready}, 0);
    chk("t4_rst_core", core_reset, 1);
    chk("t4_rst_dm", {dm_raddr, out_data}, 0);
    @(posedge Clk); #1 Reset_n = 1'b1;
    repeat (3) @(posedge Clk); #1;
    chk("t4_no_bytes", out_valid, 0);

    // 1025-word program: last word dropped, overflow set, HOLD on in_last.
    fill_mem();
    prog = {};
    for (int i = 0; i < 1025; i++) prog.push_back(9'($urandom));
    load();
    chk("t5_overflow", overflow, 1);
    chk("t5_hold", {in_ready, core_reset}, 2'b01);
    hold_check();
    run(4, 4);
    dump(70);
    chk("t5_overflow_sticky", overflow, 1);

    chk("im_q_empty", im_q.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
